// File: rtl/mos6502_pkg.sv
// Shared 6502 system constants: vector selects, vector page base and
// helpers that turn a select code into its vector address.
package mos6502_pkg;

   localparam logic [1:0]  VEC_NMI       = 2'b01;
   localparam logic [1:0]  VEC_RESET     = 2'b10;
   localparam logic [1:0]  VEC_IRQ       = 2'b11;
   localparam logic [15:0] VEC_PAGE_BASE = 16'hFFF8;

   // Select code 00 has no vector of its own and behaves as IRQ/BRK.
   function automatic logic [1:0] map_sel(input logic [1:0] sel);
      return (sel == 2'b00) ? VEC_IRQ : sel;
   endfunction

   function automatic logic [15:0] vec_lo_addr(input logic [1:0] sel);
      return VEC_PAGE_BASE | {13'h0000, sel, 1'b0};
   endfunction

endpackage

// File: rtl/vec_fetch.sv
// Reset/interrupt vector fetch sequencer: stalls the core after reset, loads
// the RESET vector, then serves NMI/IRQ vector reads on demand.
module vec_fetch
   import mos6502_pkg::*;
#(
   parameter int DUMMY_CYCLES = 5
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        vec_req,
   input  logic [1:0]  vec_sel,
   output logic        vec_busy,
   output logic        mem_rd_en,
   output logic [15:0] mem_addr,
   input  logic [7:0]  mem_rd_data,
   input  logic        mem_rd_valid,
   output logic        vec_valid,
   output logic [15:0] vec_pc,
   output logic        cpu_run
);

   typedef enum logic [2:0] {
      RST_WAIT,
      IDLE,
      LO_REQ,
      LO_WAIT,
      HI_REQ,
      HI_WAIT,
      DONE
   } state_t;

   localparam logic [7:0] LAST_COUNT = 8'(DUMMY_CYCLES - 1);

   state_t      state_reg, state_next;
   logic [7:0]  cnt_reg, cnt_next;
   logic [1:0]  sel_reg, sel_next;
   logic [7:0]  lo_reg, lo_next;
   logic [7:0]  hi_reg, hi_next;
   logic        busy_reg, busy_next;
   logic        rd_en_reg, rd_en_next;
   logic [15:0] addr_reg, addr_next;
   logic        valid_reg, valid_next;
   logic [15:0] pc_reg, pc_next;
   logic        run_reg, run_next;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= RST_WAIT;
         cnt_reg   <= 8'h00;
         sel_reg   <= VEC_RESET;
         lo_reg    <= 8'h00;
         hi_reg    <= 8'h00;
         busy_reg  <= 1'b1;
         rd_en_reg <= 1'b0;
         addr_reg  <= 16'hFFFC;
         valid_reg <= 1'b0;
         pc_reg    <= 16'h0000;
         run_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         sel_reg   <= sel_next;
         lo_reg    <= lo_next;
         hi_reg    <= hi_next;
         busy_reg  <= busy_next;
         rd_en_reg <= rd_en_next;
         addr_reg  <= addr_next;
         valid_reg <= valid_next;
         pc_reg    <= pc_next;
         run_reg   <= run_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      sel_next   = sel_reg;
      lo_next    = lo_reg;
      hi_next    = hi_reg;

      case (state_reg)
         RST_WAIT: begin
            if (cnt_reg == LAST_COUNT) begin
               sel_next   = VEC_RESET;
               state_next = LO_REQ;
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
         end
         IDLE: begin
            if (vec_req && run_reg) begin
               sel_next   = map_sel(vec_sel);
               state_next = LO_REQ;
            end
         end
         LO_REQ:  state_next = LO_WAIT;
         LO_WAIT: begin
            if (mem_rd_valid) begin
               lo_next    = mem_rd_data;
               state_next = HI_REQ;
            end
         end
         HI_REQ:  state_next = HI_WAIT;
         HI_WAIT: begin
            if (mem_rd_valid) begin
               hi_next    = mem_rd_data;
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = RST_WAIT;
      endcase
   end

   // Outputs are registered from the next state so they line up with the
   // state they describe without any input-to-output combinational path.
   always_comb begin
      rd_en_next = (state_next == LO_REQ) || (state_next == HI_REQ);
      busy_next  = (state_next != IDLE);
      addr_next  = addr_reg;
      if (state_next == LO_REQ) begin
         addr_next = vec_lo_addr(sel_next);
      end else if (state_next == HI_REQ) begin
         addr_next = addr_reg | 16'h0001;
      end
      valid_next = (state_reg == DONE);
      pc_next    = (state_reg == DONE) ? {hi_reg, lo_reg} : pc_reg;
      run_next   = run_reg || ((state_reg == DONE) && (sel_reg == VEC_RESET));
   end

   assign vec_busy  = busy_reg;
   assign mem_rd_en = rd_en_reg;
   assign mem_addr  = addr_reg;
   assign vec_valid = valid_reg;
   assign vec_pc    = pc_reg;
   assign cpu_run   = run_reg;

endmodule

// File: tb/tb_vec_fetch.sv
// Directed bench for vec_fetch: a latency-programmable memory responder plus a
// linear sequence of boot, NMI, alias, stray-valid and reset-abort steps.
module tb_vec_fetch;
   import mos6502_pkg::*;

   logic        clk;
   logic        reset_n;
   logic        vec_req;
   logic [1:0]  vec_sel;
   logic        vec_busy;
   logic        mem_rd_en;
   logic [15:0] mem_addr;
   logic [7:0]  mem_rd_data;
   logic        mem_rd_valid;
   logic        vec_valid;
   logic [15:0] vec_pc;
   logic        cpu_run;

   vec_fetch #(.DUMMY_CYCLES(5)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .vec_req      (vec_req),
      .vec_sel      (vec_sel),
      .vec_busy     (vec_busy),
      .mem_rd_en    (mem_rd_en),
      .mem_addr     (mem_addr),
      .mem_rd_data  (mem_rd_data),
      .mem_rd_valid (mem_rd_valid),
      .vec_valid    (vec_valid),
      .vec_pc       (vec_pc),
      .cpu_run      (cpu_run)
   );

   int tests  = 0;
   int failed = 0;

   int cyc;
   int lat;
   int pend;
   int stray_cnt;
   int stray_done;
   logic [15:0] paddr;
   logic [7:0]  mem [8];

   logic [15:0] rd_addr_q[$];
   int          rd_cyc_q[$];
   logic        rd_run_q[$];
   int          valid_cnt;
   int          valid_cyc;
   logic [15:0] valid_pc;
   logic        valid_run;
   logic        valid_busy;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Memory responder and monitor, both evaluated on the falling edge.
   initial begin
      mem_rd_valid = 1'b0;
      mem_rd_data  = 8'h00;
      pend         = 0;
      stray_done   = 0;
      valid_cnt    = 0;
      valid_cyc    = 0;
      valid_pc     = 16'h0000;
      valid_run    = 1'b0;
      valid_busy   = 1'b0;
      paddr        = 16'h0000;
      forever begin
         @(negedge clk);
         mem_rd_valid = 1'b0;
         if (!reset_n) pend = 0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               mem_rd_valid = 1'b1;
               mem_rd_data  = mem[paddr[2:0]];
            end
         end else if (stray_done != stray_cnt) begin
            stray_done++;
            mem_rd_valid = 1'b1;
            mem_rd_data  = 8'hEE;
         end
         if (mem_rd_en) begin
            pend  = lat;
            paddr = mem_addr;
            rd_addr_q.push_back(mem_addr);
            rd_cyc_q.push_back(cyc);
            rd_run_q.push_back(cpu_run);
         end
         if (vec_valid) begin
            valid_cnt++;
            valid_cyc  = cyc;
            valid_pc   = vec_pc;
            valid_run  = cpu_run;
            valid_busy = vec_busy;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [15:0] rd_addr_at(input int i);
      return (i < rd_addr_q.size()) ? rd_addr_q[i] : 16'hxxxx;
   endfunction

   function automatic int rd_cyc_at(input int i);
      return (i < rd_cyc_q.size()) ? rd_cyc_q[i] : -1;
   endfunction

   task automatic wait_valid(input string tag, input int max_cycles);
      int   start;
      logic seen;
      start = valid_cnt;
      seen  = 1'b0;
      for (int i = 0; i < max_cycles && !seen; i++) begin
         tick();
         if (valid_cnt != start) seen = 1'b1;
      end
      check(tag, {31'd0, seen}, 32'd1);
   endtask

   task automatic request(input logic [1:0] sel);
      vec_sel = sel;
      vec_req = 1'b1;
      tick();
      vec_req = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},  {31'd0, vec_busy},  32'd1);
      check({tag, "_rd_en"}, {31'd0, mem_rd_en}, 32'd0);
      check({tag, "_addr"},  {16'd0, mem_addr},  32'h0000_FFFC);
      check({tag, "_valid"}, {31'd0, vec_valid}, 32'd0);
      check({tag, "_pc"},    {16'd0, vec_pc},    32'h0000_0000);
      check({tag, "_run"},   {31'd0, cpu_run},   32'd0);
   endtask

   initial begin
      int rel;
      int base;
      int v0;
      logic reached;

      reset_n   = 1'b0;
      vec_req   = 1'b0;
      vec_sel   = 2'b00;
      lat       = 1;
      stray_cnt = 0;
      for (int i = 0; i < 8; i++) mem[i] = 8'h00;

      // Boot with L=1: RESET vector $1234.
      mem[4] = 8'h34;
      mem[5] = 8'h12;
      repeat (3) @(posedge clk);
      tick();
      check_reset_outputs("por");
      reset_n = 1'b1;
      rel  = cyc;
      base = rd_addr_q.size();
      v0   = valid_cnt;
      wait_valid("boot_timeout", 40);
      check("boot_rd_edge",    rd_cyc_at(base) - rel, 32'd5);
      check("boot_lo_addr",    {16'd0, rd_addr_at(base)},     32'h0000_FFFC);
      check("boot_hi_addr",    {16'd0, rd_addr_at(base + 1)}, 32'h0000_FFFD);
      check("boot_pc",         {16'd0, valid_pc},  32'h0000_1234);
      check("boot_latency",    valid_cyc - rd_cyc_at(base), 32'd5);
      check("boot_run_before", {31'd0, rd_run_q[base]}, 32'd0);
      check("boot_run_at_vld", {31'd0, valid_run},  32'd1);
      check("boot_busy_at_vld", {31'd0, valid_busy}, 32'd0);
      check("boot_valid_count", valid_cnt - v0, 32'd1);
      tick();
      check("boot_valid_pulse", {31'd0, vec_valid}, 32'd0);
      check("boot_pc_held",     {16'd0, vec_pc},    32'h0000_1234);

      // NMI after boot.
      mem[2] = 8'hAA;
      mem[3] = 8'h55;
      base = rd_addr_q.size();
      request(VEC_NMI);
      wait_valid("nmi_timeout", 40);
      check("nmi_lo_addr", {16'd0, rd_addr_at(base)},     32'h0000_FFFA);
      check("nmi_hi_addr", {16'd0, rd_addr_at(base + 1)}, 32'h0000_FFFB);
      check("nmi_pc",      {16'd0, valid_pc}, 32'h0000_55AA);
      check("nmi_run",     {31'd0, cpu_run},  32'd1);

      // sel=00 aliases to IRQ; a second request mid-fetch is dropped.
      lat    = 2;
      mem[6] = 8'h78;
      mem[7] = 8'h56;
      base = rd_addr_q.size();
      v0   = valid_cnt;
      request(2'b00);
      tick();
      check("irq_busy_mid", {31'd0, vec_busy}, 32'd1);
      vec_sel = VEC_NMI;
      vec_req = 1'b1;
      tick();
      tick();
      vec_req = 1'b0;
      wait_valid("irq_timeout", 40);
      repeat (10) tick();
      check("irq_lo_addr",   {16'd0, rd_addr_at(base)},     32'h0000_FFFE);
      check("irq_hi_addr",   {16'd0, rd_addr_at(base + 1)}, 32'h0000_FFFF);
      check("irq_pc",        {16'd0, valid_pc}, 32'h0000_5678);
      check("irq_one_valid", valid_cnt - v0, 32'd1);
      check("irq_two_reads", rd_addr_q.size() - base, 32'd2);

      // Stray read completions while idle.
      base = rd_addr_q.size();
      v0   = valid_cnt;
      for (int i = 0; i < 3; i++) begin
         stray_cnt++;
         tick();
         tick();
      end
      check("stray_no_valid", valid_cnt - v0, 32'd0);
      check("stray_no_read",  rd_addr_q.size() - base, 32'd0);
      check("stray_idle",     {31'd0, vec_busy}, 32'd0);
      check("stray_pc_held",  {16'd0, vec_pc},   32'h0000_5678);

      // RESET-vector fetch after boot with slow memory (L=4 -> 11 cycles).
      lat    = 4;
      mem[4] = 8'h00;
      mem[5] = 8'hC0;
      base = rd_addr_q.size();
      request(VEC_RESET);
      wait_valid("slow_timeout", 60);
      check("slow_lo_addr", {16'd0, rd_addr_at(base)}, 32'h0000_FFFC);
      check("slow_pc",      {16'd0, valid_pc}, 32'h0000_C000);
      check("slow_latency", valid_cyc - rd_cyc_at(base), 32'd11);
      check("slow_run",     {31'd0, cpu_run},  32'd1);

      // Reset while waiting for the high byte, then a late completion.
      lat  = 6;
      base = rd_addr_q.size();
      request(VEC_NMI);
      reached = 1'b0;
      for (int i = 0; i < 40 && !reached; i++) begin
         tick();
         if (rd_addr_q.size() >= base + 2) reached = 1'b1;
      end
      check("abort_hi_req_seen", {31'd0, reached}, 32'd1);
      tick();
      tick();
      check("abort_busy_pre", {31'd0, vec_busy}, 32'd1);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      tick();
      tick();
      mem[4] = 8'hEF;
      mem[5] = 8'hBE;
      lat    = 1;
      reset_n = 1'b1;
      rel  = cyc;
      base = rd_addr_q.size();
      v0   = valid_cnt;
      stray_cnt++;
      wait_valid("reboot_timeout", 40);
      check("reboot_rd_edge", rd_cyc_at(base) - rel, 32'd5);
      check("reboot_lo_addr", {16'd0, rd_addr_at(base)},     32'h0000_FFFC);
      check("reboot_hi_addr", {16'd0, rd_addr_at(base + 1)}, 32'h0000_FFFD);
      check("reboot_pc",      {16'd0, valid_pc}, 32'h0000_BEEF);
      check("reboot_run",     {31'd0, valid_run}, 32'd1);
      check("reboot_one_valid", valid_cnt - v0, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
